muldiv_unit: RTL and testbench

- Iterative multi-cycle multiply/divide unit implementing the RV32M operation set; it sits beside the combinational ALU in the execute stage.
- The control FSM starts it on R-type instructions with funct7 = 0000001 and waits for done_o before writeback.
- Multiply uses radix-2 shift-add and divide uses radix-2 restoring division, one bit per cycle, both generalised over DATA_WIDTH.

---
 rtl/muldiv_unit.sv | 188 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Optional MULDIV_EARLY_OUT_EN lets divide-by-zero, signed-overflow divides and zero-operand multiplies skip CALC.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  div_by_zero_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int W = DATA_WIDTH;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CALC   = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;

  logic [1:0]           state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic                 neg_q, neg_d;
  logic                 dbz_q, dbz_d;
  logic [W-1:0]         opb_q, opb_d;
  logic [2*W-1:0]       acc_q, acc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 dbz_out_q, dbz_out_d;
  logic [W-1:0]         result_q, result_d;

  logic         is_div, a_signed, b_signed, sign_a, sign_b, b_zero, start_neg;
  logic [W-1:0] mag_a, mag_b;
`ifdef MULDIV_EARLY_OUT_EN
  logic         div_ovf, mul_zero;
`endif

  // Operand decode for the acceptance cycle: magnitudes plus the sign the final result must carry.
  always_comb begin
    is_div   = funct3_i[2];
    a_signed = (funct3_i == OP_MULH) || (funct3_i == OP_MULHSU) ||
               (funct3_i == OP_DIV)  || (funct3_i == OP_REM);
    b_signed = (funct3_i == OP_MULH) || (funct3_i == OP_DIV) || (funct3_i == OP_REM);
    sign_a   = a_signed & a_i[W-1];
    sign_b   = b_signed & b_i[W-1];
    mag_a    = sign_a ? -a_i : a_i;
    mag_b    = sign_b ? -b_i : b_i;
    b_zero   = (b_i == '0);
    if (!is_div) begin
      start_neg = sign_a ^ sign_b;
    end else if (funct3_i[1]) begin
      start_neg = sign_a;
    end else begin
      // A zero divisor must yield all ones, so the quotient is never negated.
      start_neg = (sign_a ^ sign_b) & ~b_zero;
    end
`ifdef MULDIV_EARLY_OUT_EN
    div_ovf  = ((funct3_i == OP_DIV) || (funct3_i == OP_REM)) &&
               (a_i == {1'b1, {(W-1){1'b0}}}) && (b_i == '1);
    mul_zero = (a_i == '0) || b_zero;
`endif
  end

  logic [W:0]     mul_sum, div_shift, div_diff;
  logic [2*W-1:0] mul_next, div_next;

  // acc holds {product_hi, multiplier} for multiply and {remainder, dividend/quotient} for divide.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, opb_q};
    mul_next  = acc_q[0] ? {mul_sum, acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:1]};
    div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    div_next  = div_diff[W] ? {div_shift[W-1:0], acc_q[W-2:0], 1'b0}
                            : {div_diff[W-1:0],  acc_q[W-2:0], 1'b1};
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    neg_d   = neg_q;
    dbz_d   = dbz_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          op_d    = funct3_i;
          neg_d   = start_neg;
          dbz_d   = is_div & b_zero;
          cnt_d   = CNT_WIDTH'(W);
          state_d = S_CALC;
          if (is_div) begin
            opb_d = mag_b;
            acc_d = {{W{1'b0}}, mag_a};
          end else begin
            opb_d = mag_a;
            acc_d = {{W{1'b0}}, mag_b};
          end
`ifdef MULDIV_EARLY_OUT_EN
          // Preload acc with what the full iteration would have produced.
          if (is_div && b_zero) begin
            acc_d   = {mag_a, {W{1'b1}}};
            state_d = S_FINISH;
          end else if (div_ovf) begin
            state_d = S_FINISH;
          end else if (!is_div && mul_zero) begin
            acc_d   = '0;
            state_d = S_FINISH;
          end
`endif
        end
      end
      S_CALC: begin
        acc_d = op_q[2] ? div_next : mul_next;
        cnt_d = cnt_q - CNT_WIDTH'(1);
        if (cnt_q == CNT_WIDTH'(1)) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quot_fix, rem_fix, fin_result;

  // The result register is loaded on the edge entering FINISH so it is valid alongside done_o.
  always_comb begin
    prod_fix = neg_d ? -acc_d : acc_d;
    quot_fix = neg_d ? -acc_d[W-1:0] : acc_d[W-1:0];
    rem_fix  = neg_d ? -acc_d[2*W-1:W] : acc_d[2*W-1:W];
    case (op_d)
      OP_MUL:                       fin_result = prod_fix[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin_result = prod_fix[2*W-1:W];
      OP_DIV, OP_DIVU:              fin_result = quot_fix;
      default:                      fin_result = rem_fix;
    endcase
    done_d    = (state_d == S_FINISH);
    result_d  = done_d ? fin_result : result_q;
    dbz_out_d = done_d ? dbz_d : dbz_out_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      neg_q     <= 1'b0;
      dbz_q     <= 1'b0;
      opb_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      dbz_q     <= dbz_d;
      opb_q     <= opb_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      dbz_out_q <= dbz_out_d;
      result_q  <= result_d;
    end
  end

  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = done_q;
  assign div_by_zero_o = dbz_out_q;
  assign result_o      = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M vectors, latency, busy window, ignored start and reset abort.
module tb_muldiv_unit;

  localparam int W = 32;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif

  logic         clk_i = 1'b0;
  logic         rst_i, start_i;
  logic [2:0]   funct3_i;
  logic [W-1:0] a_i, b_i;
  logic         busy_o, done_o, div_by_zero_o;
  logic [W-1:0] result_o;

  muldiv_unit #(.DATA_WIDTH(W)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .funct3_i      (funct3_i),
    .a_i           (a_i),
    .b_i           (b_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .div_by_zero_o (div_by_zero_o),
    .result_o      (result_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         dbz;
    int unsigned  cyc;
    int           tag;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   tag_n        = 0;
  bit   check_idle   = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic int unsigned expLatency(input logic early);
    return (early && EARLY_EN) ? 1 : W + 1;
  endfunction

  // Issues one op in the first idle cycle; the expected response is queued before the DUT sees it.
  task automatic applyStimulus(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] res, input logic dbz, input logic early,
                               input logic expect_done, output int unsigned acc_cyc);
    int guard = 0;
    @(negedge clk_i);
    while (busy_o && guard < 200) begin
      @(negedge clk_i);
      guard++;
    end
    if (guard >= 200) checkOutput("idle_wait_timeout", 64'(busy_o), 64'(0));
    funct3_i = f;
    a_i      = a;
    b_i      = b;
    start_i  = 1'b1;
    acc_cyc  = cyc + 1;
    if (expect_done) begin
      exp_q.push_back('{res: res, dbz: dbz, cyc: cyc + expLatency(early), tag: tag_n});
    end
    tag_n++;
    @(negedge clk_i);
    start_i  = 1'b0;
    funct3_i = 3'($urandom);
    a_i      = $urandom;
    b_i      = $urandom;
    checkOutput("busy_after_accept", 64'(busy_o), 64'(1));
  endtask

  // Monitor: pops the scoreboard on every done_o and checks the cycle after it is idle.
  always @(negedge clk_i) begin : monitor
    exp_t e;
    if (check_idle) begin
      checkOutput("busy_after_done", 64'(busy_o), 64'(0));
      check_idle = 1'b0;
    end
    if (done_o) begin
      check_idle = 1'b1;
      if (exp_q.size() == 0) begin
        checkOutput("spurious_done", 64'(done_o), 64'(0));
      end else begin
        e = exp_q.pop_front();
        checkOutput($sformatf("result#%0d", e.tag), 64'(result_o), 64'(e.res));
        checkOutput($sformatf("div_by_zero#%0d", e.tag), 64'(div_by_zero_o), 64'(e.dbz));
        checkOutput($sformatf("done_cycle#%0d", e.tag), 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin : stimulus
    int unsigned acc;
    int guard;
    rst_i    = 1'b1;
    start_i  = 1'b0;
    funct3_i = 3'b000;
    a_i      = '0;
    b_i      = '0;
    repeat (3) @(negedge clk_i);
    checkOutput("reset_busy", 64'(busy_o), 64'(0));
    checkOutput("reset_done", 64'(done_o), 64'(0));
    checkOutput("reset_result", 64'(result_o), 64'(0));
    checkOutput("reset_dbz", 64'(div_by_zero_o), 64'(0));
    rst_i = 1'b0;

    //             funct3  a             b             result        dbz   early
    applyStimulus(3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 1'b0, 1'b1, acc);
    applyStimulus(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 1'b0, 1'b1, acc);
    applyStimulus(3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 1'b0, 1'b1, acc);
    applyStimulus(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, acc);
    applyStimulus(3'b001, 32'hFFFFFFFF, 32'd5,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, acc);
    applyStimulus(3'b100, 32'hFFFFFFEC, 32'd6,        32'hFFFFFFFD, 1'b0, 1'b0, 1'b1, acc);
    applyStimulus(3'b110, 32'hFFFFFFEC, 32'd6,        32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, acc);
    applyStimulus(3'b101, 32'd20,       32'd6,        32'd3,        1'b0, 1'b0, 1'b1, acc);
    applyStimulus(3'b111, 32'd20,       32'd6,        32'd2,        1'b0, 1'b0, 1'b1, acc);
    applyStimulus(3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b1, acc);
    applyStimulus(3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        1'b0, 1'b0, 1'b1, acc);
    applyStimulus(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1, 1'b1, acc);
    applyStimulus(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b0, 1'b1, 1'b1, acc);
    applyStimulus(3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, acc);
    applyStimulus(3'b111, 32'd5,        32'd0,        32'd5,        1'b1, 1'b1, 1'b1, acc);
    applyStimulus(3'b100, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, acc);
    applyStimulus(3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1'b1, 1'b1, 1'b1, acc);
    applyStimulus(3'b000, 32'd0,        32'd12345,    32'd0,        1'b0, 1'b1, 1'b1, acc);

    // A start pulse in the middle of a divide must be dropped without a second done_o.
    applyStimulus(3'b101, 32'd100,      32'd7,        32'd14,       1'b0, 1'b0, 1'b1, acc);
    while (cyc < acc + 9) @(negedge clk_i);
    funct3_i = 3'b000;
    a_i      = 32'd3;
    b_i      = 32'd4;
    start_i  = 1'b1;
    @(negedge clk_i);
    start_i  = 1'b0;
    applyStimulus(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, acc);
    applyStimulus(3'b111, 32'd100,      32'd7,        32'd2,        1'b0, 1'b0, 1'b1, acc);

    // Reset during cycle 15 of a multiply aborts it silently.
    applyStimulus(3'b000, 32'h1234,     32'h10,       32'd0,        1'b0, 1'b0, 1'b0, acc);
    while (cyc < acc + 14) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    checkOutput("abort_busy", 64'(busy_o), 64'(0));
    checkOutput("abort_result", 64'(result_o), 64'(0));
    checkOutput("abort_done", 64'(done_o), 64'(0));
    rst_i = 1'b0;
    repeat (50) @(negedge clk_i);

    applyStimulus(3'b000, 32'd3,        32'd5,        32'd15,       1'b0, 1'b0, 1'b1, acc);

    guard = 0;
    while (exp_q.size() > 0 && guard < 200) begin
      @(negedge clk_i);
      guard++;
    end
    checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    @(negedge clk_i);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
